// File: rtl/display_scan_if.sv
// display_scan_if: groups the BCD load port and the scanned display outputs
// of display_scan. The slave modport is the scanner side; the master modport
// is the producer/consumer side (measurement counter and segment decoder).
interface display_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] bcd;
  logic                load;
  logic [3:0]          hex;
  logic [DIGITS-1:0]   digit_sel;
  logic                blank;
  logic [2:0]          digit_idx;

  modport master (
    output bcd, load,
    input  hex, digit_sel, blank, digit_idx
  );

  modport slave (
    input  bcd, load,
    output hex, digit_sel, blank, digit_idx
  );
endinterface

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment digit scanner.
// Latches packed BCD into a shadow register on load, walks the digits at one
// slot per PRESCALE cycles, and presents one nibble plus an active-low digit
// select per slot, with an all-off window of DEAD cycles at each slot start.
// Optional leading-zero blanking is built when DISPLAY_SCAN_LZB_EN is defined;
// otherwise blank is tied low and no blanking logic exists.
module display_scan #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 1000,
  parameter int DEAD     = 2
) (
  input logic         clk,
  input logic         rst_n,
  display_scan_if.slave bus
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PC_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   DEAD_C   = PW'(DEAD);
  localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow_reg;
  logic [PW-1:0]       pc_reg;
  logic [PW-1:0]       pc_next;
  logic [2:0]          idx_reg;
  logic [2:0]          idx_next;
  logic [3:0]          hex_reg;
  logic [DIGITS-1:0]   sel_reg;
  logic [DIGITS-1:0]   sel_next;
  logic                boundary;

  // Shadow nibbles padded out to the full 3-bit index range so any idx value
  // selects a defined nibble without width juggling.
  logic [3:0] nib [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      if (gi < DIGITS) begin : g_real
        assign nib[gi] = shadow_reg[4*gi +: 4];
      end else begin : g_pad
        assign nib[gi] = 4'h0;
      end
    end
  endgenerate

  // Next prescaler / index values; the slot boundary is the edge leaving pc=PRESCALE-1.
  always_comb begin
    boundary = (pc_reg == PC_LAST);
    pc_next  = boundary ? '0 : pc_reg + PW'(1);
    idx_next = idx_reg;
    if (boundary) begin
      idx_next = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
    end
    // Select is computed for the state being entered so the registered output
    // lines up with pc: all off during the dead window, then one digit low.
    if (pc_next < DEAD_C) begin
      sel_next = '1;
    end else begin
      sel_next = ~(DIGITS'(1) << idx_next);
    end
  end

  // Shadow register: only changes on a load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
    end else if (bus.load) begin
      shadow_reg <= bus.bcd;
    end
  end

  // Prescaler, digit index, select and nibble; the nibble is sampled from the
  // pre-load shadow at the boundary so a same-edge load waits one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg  <= '0;
      idx_reg <= 3'd0;
      sel_reg <= '1;
      hex_reg <= 4'h0;
    end else begin
      pc_reg  <= pc_next;
      idx_reg <= idx_next;
      sel_reg <= sel_next;
      if (boundary) begin
        hex_reg <= nib[idx_next];
      end
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // zero_above[i] is high when nibbles i..DIGITS-1 are all zero.
  logic [DIGITS:0] zero_above;
  logic [7:0]      blank_vec;
  logic            blank_reg;

  assign zero_above[DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lzb
      if (gi >= DIGITS) begin : g_pad
        assign blank_vec[gi] = 1'b0;
      end else if (gi == 0) begin : g_d0
        assign zero_above[gi] = (nib[gi] == 4'h0) && zero_above[gi+1];
        assign blank_vec[gi]  = 1'b0;
      end else begin : g_dn
        assign zero_above[gi] = (nib[gi] == 4'h0) && zero_above[gi+1];
        assign blank_vec[gi]  = zero_above[gi];
      end
    end
  endgenerate

  // Blank flag follows the same boundary timing as the nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_reg <= 1'b0;
    end else if (boundary) begin
      blank_reg <= blank_vec[idx_next];
    end
  end

  assign bus.blank = blank_reg;
`else
  assign bus.blank = 1'b0;
`endif

  assign bus.hex       = hex_reg;
  assign bus.digit_sel = sel_reg;
  assign bus.digit_idx = idx_reg;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: two scanners (DEAD=1 and DEAD=0, both 4 digits, PRESCALE=4)
// share bcd/load and have separate resets. A timeline model predicts every
// output from elapsed cycles since reset and the shadow snapshot taken at the
// most recent slot boundary.
module tb_display_scan;
  localparam int D = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic [1:0]  rst_n_v = 2'b00;
  logic [15:0] bcd_drv = 16'h0;
  logic        load_drv = 1'b0;

  display_scan_if #(.DIGITS(D)) bus_a ();
  display_scan_if #(.DIGITS(D)) bus_b ();

  assign bus_a.bcd  = bcd_drv;
  assign bus_a.load = load_drv;
  assign bus_b.bcd  = bcd_drv;
  assign bus_b.load = load_drv;

  display_scan #(.DIGITS(D), .PRESCALE(P), .DEAD(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_v[0]),
    .bus   (bus_a)
  );

  display_scan #(.DIGITS(D), .PRESCALE(P), .DEAD(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_v[1]),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          t    [2] = '{0, 0};
  logic [15:0] shd  [2] = '{16'h0, 16'h0};
  logic [15:0] snap [2] = '{16'h0, 16'h0};
  int          dead [2] = '{1, 0};

  function automatic logic [3:0] nib_of(input logic [15:0] v, input int i);
    logic [15:0] s;
    s = v >> (4 * i);
    return s[3:0];
  endfunction

  function automatic logic blank_of(input logic [15:0] v, input int i);
`ifdef DISPLAY_SCAN_LZB_EN
    return (i != 0) && ((v >> (4 * i)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag);
    for (int k = 0; k < 2; k++) begin
      int         idx;
      logic [3:0] eh, oh, es, os;
      logic       eb, ob;
      logic [2:0] ei, oi;
      idx = (t[k] / P) % D;
      ei  = 3'(idx);
      eh  = nib_of(snap[k], idx);
      eb  = blank_of(snap[k], idx);
      if (t[k] == 0 || (t[k] % P) < dead[k]) es = 4'hF;
      else es = ~(4'b0001 << idx);
      if (k == 0) begin
        oh = bus_a.hex; os = bus_a.digit_sel; ob = bus_a.blank; oi = bus_a.digit_idx;
      end else begin
        oh = bus_b.hex; os = bus_b.digit_sel; ob = bus_b.blank; oi = bus_b.digit_idx;
      end
      n_assert++;
      assert (oh === eh) else begin
        n_fail++; $error("FAIL %s_hex dut%0d t=%0d: observed %h expected %h", tag, k, t[k], oh, eh);
      end
      n_assert++;
      assert (os === es) else begin
        n_fail++; $error("FAIL %s_sel dut%0d t=%0d: observed %b expected %b", tag, k, t[k], os, es);
      end
      n_assert++;
      assert (ob === eb) else begin
        n_fail++; $error("FAIL %s_blank dut%0d t=%0d: observed %b expected %b", tag, k, t[k], ob, eb);
      end
      n_assert++;
      assert (oi === ei) else begin
        n_fail++; $error("FAIL %s_idx dut%0d t=%0d: observed %0d expected %0d", tag, k, t[k], oi, ei);
      end
    end
  endtask

  // One clock: drive inputs, advance the model over the edge, check after it.
  task automatic step(input logic ld, input logic [15:0] val, input string tag);
    load_drv = ld;
    bcd_drv  = val;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n_v[k]) begin
        t[k]++;
        if (t[k] % P == 0) snap[k] = shd[k];
        if (ld) shd[k] = val;
      end
    end
    #1;
    load_drv = 1'b0;
    check(tag);
  endtask

  task automatic hold_reset(input int k);
    rst_n_v[k] = 1'b0;
    t[k] = 0; shd[k] = 16'h0; snap[k] = 16'h0;
  endtask

  task automatic wait_phase(input int k, input int phase, input string tag);
    int i;
    for (i = 0; i < 64 && (t[k] % (P * D)) != phase; i++) step(1'b0, 16'h0, tag);
    n_assert++;
    assert ((t[k] % (P * D)) == phase) else begin
      n_fail++; $error("FAIL %s_timeout: observed phase %0d expected %0d", tag, t[k] % (P * D), phase);
    end
  endtask

  initial begin
    logic [15:0] r;
    int          nz;

    // Reset held for three cycles, released away from the clock edge.
    hold_reset(0); hold_reset(1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, "reset");
    @(negedge clk);
    rst_n_v = 2'b11;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, "post_reset");

    // Basic scan of 1234 over more than a full period.
    step(1'b1, 16'h1234, "scan_load");
    for (int i = 0; i < 24; i++) step(1'b0, 16'h0, "scan");

    // Leading-zero cases.
    step(1'b1, 16'h0050, "lzb_load");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, "lzb_0050");
    step(1'b1, 16'h0000, "lzb_load0");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, "lzb_0000");
    step(1'b1, 16'h0A00, "inv_load");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, "invalid_bcd");

    // Load 9999 on the boundary edge into slot 2 while shadow holds 1234.
    step(1'b1, 16'h1234, "bnd_pre");
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0, "bnd_fill");
    wait_phase(0, 7, "bnd_wait");
    step(1'b1, 16'h9999, "bnd_load");
    n_assert++;
    assert (bus_a.hex === 4'h2) else begin
      n_fail++; $error("FAIL bnd_slot2: observed %h expected %h", bus_a.hex, 4'h2);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, "bnd_after");

    // Asynchronous reset of dut_a during slot 2 with pc=2.
    wait_phase(0, 10, "mid_wait");
    @(negedge clk);
    hold_reset(0);
    #1;
    check("mid_rst_async");
    step(1'b0, 16'h0, "mid_rst_hold");
    step(1'b0, 16'h0, "mid_rst_hold");
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, "mid_rst_rescan");

    // Random loads, including values with leading zero nibbles.
    for (int i = 0; i < 400; i++) begin
      r  = 16'($urandom);
      nz = $urandom_range(0, 4);
      r  = (nz == 4) ? 16'h0 : (r & (16'hFFFF >> (4 * nz)));
      step(($urandom_range(0, 5) == 0), r, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scanner for the frequency meter's 7-segment display. It latches a packed BCD result from the measurement counter and steps through the digits at a prescaled refresh rate. For each digit it presents one nibble plus an active-low digit select. It sits directly upstream of the hex-to-segment decoder: its `HEX` output feeds the decoder's 4-bit input, and `DIGIT_SEL` drives the common-anode lines.

## Interface
- `DIGITS`, default 8: number of display digits; legal range 2..8.
- `PRESCALE`, default 1000: clock cycles per digit slot; must be ≥ 2.
- `DEAD`, default 2: cycles at the start of each slot with all digits off (anti-ghosting); legal range 0..PRESCALE-1.

- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `BCD`  in  4*DIGITS  packed digits; digit 0 (least significant) is `BCD[3:0]`.
- `LOAD`  in  1  single-cycle strobe; latches `BCD` into the shadow register.
- `HEX`  out  4  nibble of the current digit, to the segment decoder.
- `DIGIT_SEL`  out  DIGITS  active-low digit enable; at most one bit is low.
- `BLANK`  out  1  high when the current digit is a suppressed leading zero; the downstream logic forces all segments off.
- `DIGIT_IDX`  out  3  index of the current slot.

## Operation
- **Shadow register**
  - On any edge with `LOAD`=1, shadow ← `BCD`.
  - The shadow holds its value otherwise. Display content changes only through the shadow.
- **Prescaler**
  - Counter `pc` counts 0..PRESCALE-1 and then wraps to 0.
  - The edge where `pc`=PRESCALE-1 is the slot boundary.
- **Digit index**
  - At a slot boundary, `idx` ← `idx`+1, wrapping from DIGITS-1 to 0.
  - Scan order is 0,1,…,DIGITS-1,0,…
- **HEX and BLANK**
  - Both are loaded only at a slot boundary, from the shadow nibble of the new `idx`.
  - They are stable for the whole slot.
- **DIGIT_SEL**
  - All ones while `pc` < DEAD.
  - `~(1<<idx)` while `pc` ≥ DEAD.
- **Leading-zero rule**
  - Digit i is blanked when i ≠ 0 and shadow nibbles i..DIGITS-1 are all 4'h0.
  - Digit 0 is never blanked.
- **Invalid BCD**
  - Nibbles > 9 pass through unchanged.
  - They count as non-zero for the blanking rule.
- **Outputs**
  - All outputs are registered.
  - `DIGIT_IDX` equals `idx`.

## Timing
- **Reset (RESET_N low)**
  - `pc`=0, `idx`=0, shadow=0.
  - `HEX`=4'h0, `BLANK`=0, `DIGIT_IDX`=0, `DIGIT_SEL`=all ones.
- **After reset release**
  - Slot 0 starts on the first edge.
  - Digit 0 is enabled from the DEAD-th cycle after release.
  - The first boundary occurs after PRESCALE cycles.
- **Full scan period:** DIGITS×PRESCALE cycles.
- **LOAD latency**
  - A new value appears on `HEX` no earlier than the next slot boundary after the LOAD edge.
  - A digit already on display is never updated mid-slot.
- **LOAD and boundary on the same edge**
  - The new slot's `HEX`/`BLANK` use the pre-load shadow.
  - The new value takes effect from the following boundary.
- **Reset mid-slot**
  - Applies immediately and asynchronously.
  - Takes effect in all state, including the shadow.
- **DEAD=0**
  - `DIGIT_SEL` is low for the entire slot.
  - There is no all-off gap between digits.

## Configuration
- **`DISPLAY_SCAN_LZB_EN` defined:** leading-zero blanking as specified above.
- **`DISPLAY_SCAN_LZB_EN` undefined**
  - `BLANK` is constant 0, including through reset.
  - All digits are shown, including leading zeros.
  - No blanking logic is synthesised.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, DEAD=1 unless stated otherwise.

- **Reset:** hold RESET_N=0 for 3 cycles → `DIGIT_SEL`=4'b1111, `HEX`=0, `BLANK`=0, `DIGIT_IDX`=0. After release → `DIGIT_SEL`=4'b1110 from cycle 1 to cycle 3.
- **Scan:** LOAD `BCD`=16'h1234, then run 16 cycles → `HEX` sequence 4,3,2,1, each held 4 cycles. `DIGIT_SEL` sequence 1110,1101,1011,0111, each preceded by one cycle of 1111. Index wraps 3→0.
- **Blanking (LZB_EN defined):** LOAD 16'h0050 → `BLANK`=1 on digits 3 and 2, 0 on digits 1 and 0. LOAD 16'h0000 → only digit 0 unblanked, with `HEX`=0.
- **Load at boundary:** assert LOAD with 16'h9999 on the boundary edge into slot 2 while the shadow holds 16'h1234 → slot 2 shows `HEX`=2, slot 3 shows 9.
- **Reset mid-scan:** pull RESET_N low during slot 2, `pc`=2 → all outputs take their reset values within the same cycle, and shadow reads 0 on the next scan.
- **DEAD=0 with LZB_EN undefined:** LOAD 16'h0007 → `DIGIT_SEL` is never 4'b1111 after reset release, and `BLANK`=0 throughout with `HEX` 7,0,0,0.
